perf_counter_bank: RTL and testbench

//  Multi-channel cycle/event counter bank for CPU performance statistics
//  (stall, bubble, branch, halt cycles). Each channel counts clocks on which
//  its event input is asserted, with a per-channel polarity select.

---
 rtl/perf_counter_bank.sv | 118 +++++++++++
 tb/tb_perf_counter_bank.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// Multi-channel event counter bank with sticky overflow flags and a registered readout mux.
// Optional build macro PERF_SNAPSHOT_EN adds shadow registers so that reads of several channels see the same instant.
module perf_counter_bank #(
  parameter int                  WIDTH    = 16,
  parameter int                  CHANNELS = 4,
  parameter logic [CHANNELS-1:0] INV_MASK = '0,
  parameter bit                  SATURATE = 1'b0,
  parameter int                  SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                RST_N,
  input  logic                clr,
  input  logic                freeze,
  input  logic [CHANNELS-1:0] event_in,
  input  logic                snap,
  input  logic [SELW-1:0]     sel,
  output logic [WIDTH-1:0]    rd_data,
  output logic [CHANNELS-1:0] ovf
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  function automatic logic [WIDTH-1:0] cnt_step(input logic [WIDTH-1:0] cur);
    if (cur == CNT_MAX) begin
      return SATURATE ? CNT_MAX : '0;
    end
    return cur + 1'b1;
  endfunction

  logic [CHANNELS-1:0] hit;
  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic [WIDTH-1:0]    src   [CHANNELS];
  logic [WIDTH-1:0]    rd_q, rd_d;

  // Counter update: clr beats freeze, freeze beats counting.
  always_comb begin
    hit = event_in ^ INV_MASK;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (clr) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (!freeze && hit[i]) begin
        cnt_d[i] = cnt_step(cnt_q[i]);
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end
      end
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [WIDTH-1:0] shadow_q [CHANNELS];
  logic [WIDTH-1:0] shadow_d [CHANNELS];

  // Snapshots take the pre-update count regardless of clr/freeze.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      shadow_d[i] = snap ? cnt_q[i] : shadow_q[i];
      src[i]      = shadow_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!RST_N) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end
`else
  logic unused_snap;
  assign unused_snap = snap;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      src[i] = cnt_q[i];
    end
  end
`endif

  // Out-of-range selects read as zero.
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(sel) == i) begin
        rd_d = src[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RST_N) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q <= '0;
      rd_q  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ovf_q <= ovf_d;
      rd_q  <= rd_d;
    end
  end

  assign rd_data = rd_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: default 16-bit/4-channel instance plus
// two 4-bit/3-channel instances (wrap and saturate) sharing one stimulus.
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        RST_N, clr, freeze, snap;
  logic [3:0]  ev;
  logic [1:0]  sel;
  logic [15:0] rd_def;
  logic [3:0]  ovf_def;
  logic [3:0]  rd_w, rd_s;
  logic [2:0]  ovf_w, ovf_s;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  perf_counter_bank u_def (
    .clk(clk), .RST_N(RST_N), .clr(clr), .freeze(freeze), .event_in(ev),
    .snap(snap), .sel(sel), .rd_data(rd_def), .ovf(ovf_def)
  );

  perf_counter_bank #(
    .WIDTH(4), .CHANNELS(3), .INV_MASK(3'b010), .SATURATE(1'b0)
  ) u_w (
    .clk(clk), .RST_N(RST_N), .clr(clr), .freeze(freeze), .event_in(ev[2:0]),
    .snap(snap), .sel(sel), .rd_data(rd_w), .ovf(ovf_w)
  );

  perf_counter_bank #(
    .WIDTH(4), .CHANNELS(3), .INV_MASK(3'b010), .SATURATE(1'b1)
  ) u_s (
    .clk(clk), .RST_N(RST_N), .clr(clr), .freeze(freeze), .event_in(ev[2:0]),
    .snap(snap), .sel(sel), .rd_data(rd_s), .ovf(ovf_s)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    RST_N = 1'b0; clr = 1'b0; freeze = 1'b0; snap = 1'b0;
    ev = 4'b1111; sel = 2'd0;
    tick(2);
    check("reset_rd_def",  32'(rd_def),  0);
    check("reset_ovf_def", 32'(ovf_def), 0);
    check("reset_rd_w",    32'(rd_w),    0);
    check("reset_ovf_w",   32'(ovf_w),   0);

`ifdef PERF_SNAPSHOT_EN
    RST_N = 1'b1; ev = 4'b0011;
    tick(5);
    snap = 1'b1; clr = 1'b1;
    tick(1);
    check("snap_rd_before", 32'(rd_def), 0);
    snap = 1'b0; clr = 1'b0;
    tick(1);
    check("snap_rd_shadow", 32'(rd_def), 5);
    check("snap_rd_w",      32'(rd_w),   5);
    tick(3);
    check("snap_rd_hold",   32'(rd_def), 5);
    snap = 1'b1;
    tick(1);
    check("snap2_rd_old",   32'(rd_def), 5);
    snap = 1'b0;
    tick(1);
    check("snap2_rd_new",   32'(rd_def), 4);
`else
    // Counting starts at the first edge with RST_N high
    RST_N = 1'b1;
    tick(10);
    check("t1_rd_def_9", 32'(rd_def), 9);
    check("t1_rd_w_9",   32'(rd_w),   9);
    tick(1);
    check("t1_rd_def_10", 32'(rd_def), 10);
    ev = 4'b0000; clr = 1'b1;
    tick(1);
    clr = 1'b0;

    // Inverted channel 1 counts while its event is low
    sel = 2'd1;
    tick(5);
    ev = 4'b0010;
    tick(1);
    check("t2_ch1_inv", 32'(rd_w), 5);
    sel = 2'd0;
    tick(1);
    check("t2_ch0_zero", 32'(rd_w), 0);
    check("t2_ovf_w",    32'(ovf_w), 0);

    // Wrap vs saturate past max
    ev = 4'b0011; clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(17);
    ev = 4'b0010;
    tick(1);
    check("t3_wrap_cnt",  32'(rd_w),    1);
    check("t3_sat_cnt",   32'(rd_s),    15);
    check("t3_def_cnt",   32'(rd_def),  17);
    check("t3_wrap_ovf",  32'(ovf_w),   1);
    check("t3_sat_ovf",   32'(ovf_s),   1);
    check("t3_def_ovf",   32'(ovf_def), 0);

    // clr drops a coincident hit; freeze holds
    ev = 4'b0011; clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(7);
    clr = 1'b1;
    tick(1);
    check("t4_rd_pre_clr", 32'(rd_w), 7);
    clr = 1'b0; ev = 4'b0010;
    tick(1);
    check("t4_rd_cleared", 32'(rd_w),  0);
    check("t4_ovf_clear",  32'(ovf_w), 0);
    ev = 4'b0011;
    tick(3);
    freeze = 1'b1;
    tick(3);
    freeze = 1'b0; ev = 4'b0010;
    tick(1);
    check("t4_freeze_w",   32'(rd_w),   3);
    check("t4_freeze_def", 32'(rd_def), 3);

    // Out-of-range select and one-cycle select latency
    sel = 2'd3; ev = 4'b0110;
    tick(4);
    check("t5_sel_oob", 32'(rd_w), 0);
    ev = 4'b0010; sel = 2'd0;
    tick(1);
    check("t5_sel0", 32'(rd_w), 3);
    sel = 2'd2;
    tick(1);
    check("t5_sel2", 32'(rd_w), 4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
